// File: rtl/calc_pkg.sv
// +----------------------------------------------------------------------+
// | calc_pkg                                                              |
// | Shared types and constants for the calculator result formatter.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

  localparam int CONV_CYCLES = 32;
  localparam int NUM_DIGITS  = 10;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS   = 3'd1,
    ST_CONV  = 3'd2,
    ST_SIGN  = 3'd3,
    ST_DIGIT = 3'd4,
    ST_CR    = 3'd5,
    ST_LF    = 3'd6,
    ST_DONE  = 3'd7
  } fmt_state_t;

  // Position of the most significant nonzero BCD digit; 0 when all digits are zero.
  function automatic logic [3:0] msd_index(input logic [4*NUM_DIGITS-1:0] bcd);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +----------------------------------------------------------------------+
// | bin2bcd_seq                                                           |
// | Sequential 32-bit binary to 10-digit BCD converter (double dabble).   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [31:0]             mag,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [31:0]             r_bin;
  logic [5:0]              r_cnt;
  logic                    r_active;
  logic                    r_done;

  logic [4*NUM_DIGITS-1:0] w_src_bcd;
  logic [31:0]             w_src_bin;
  logic [4*NUM_DIGITS+31:0] w_step;

  function automatic logic [4*NUM_DIGITS+31:0] dd_step(
    input logic [4*NUM_DIGITS-1:0] b,
    input logic [31:0]             x
  );
    logic [4*NUM_DIGITS-1:0] adj;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {adj, x} << 1;
  endfunction

  // The first iteration runs on the start edge so the result lands after 32 cycles.
  assign w_src_bcd = start ? '0  : r_bcd;
  assign w_src_bin = start ? mag : r_bin;
  assign w_step    = dd_step(w_src_bcd, w_src_bin);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        {r_bcd, r_bin} <= w_step;
        r_cnt          <= 6'd1;
        r_active       <= 1'b1;
      end else if (r_active) begin
        {r_bcd, r_bin} <= w_step;
        r_cnt          <= r_cnt + 6'd1;
        if (r_cnt == 6'(CONV_CYCLES - 1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign bcd  = r_bcd;
  assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/res_formatter.sv
// +----------------------------------------------------------------------+
// | res_formatter                                                         |
// | Formats a 32-bit ALU result as signed decimal ASCII plus CR LF.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module res_formatter
  import calc_pkg::*;
#(
  parameter int EOL_EN = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        alu_done,
  input  logic [31:0] calc_res,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        fmt_busy,
  output logic        fmt_done
);

  fmt_state_t r_state;
  fmt_state_t w_next;

  logic [31:0]             r_res;
  logic                    r_neg;
  logic [3:0]              r_idx;

  logic [31:0]             w_mag;
  logic                    w_start;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic                    w_conv_done;
  logic                    w_xfer;
  logic [3:0]              w_digit;

  assign w_mag   = r_res[31] ? (~r_res + 32'd1) : r_res;
  assign w_start = (r_state == ST_ABS);
  assign w_xfer  = tx_valid && tx_ready;
  assign w_digit = w_bcd[{r_idx, 2'b00} +: 4];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .n_rst (n_rst),
    .start (w_start),
    .mag   (w_mag),
    .bcd   (w_bcd),
    .done  (w_conv_done)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && alu_done) r_res <= calc_res;
      if (r_state == ST_ABS) r_neg <= r_res[31];
      if (r_state == ST_CONV && w_conv_done) r_idx <= msd_index(w_bcd);
      else if (r_state == ST_DIGIT && w_xfer && r_idx != 4'd0) r_idx <= r_idx - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (alu_done) w_next = ST_ABS;
      ST_ABS:   w_next = ST_CONV;
      ST_CONV:  if (w_conv_done) w_next = r_neg ? ST_SIGN : ST_DIGIT;
      ST_SIGN:  if (w_xfer) w_next = ST_DIGIT;
      ST_DIGIT: if (w_xfer && r_idx == 4'd0) w_next = (EOL_EN != 0) ? ST_CR : ST_DONE;
      ST_CR:    if (w_xfer) w_next = ST_LF;
      ST_LF:    if (w_xfer) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so tx_ready never reaches tx_valid.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    fmt_busy = (r_state != ST_IDLE);
    fmt_done = (r_state == ST_DONE);
    case (r_state)
      ST_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_MINUS;
      end
      ST_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_0 + {4'd0, w_digit};
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_res_formatter.sv
// +----------------------------------------------------------------------+
// | tb_res_formatter                                                      |
// | Self-checking bench for res_formatter against a decimal-string model. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_res_formatter;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        alu_done = 1'b0;
  logic [31:0] calc_res = 32'd0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        fmt_busy;
  logic        fmt_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  res_formatter #(.EOL_EN(1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .alu_done (alu_done),
    .calc_res (calc_res),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .fmt_busy (fmt_busy),
    .fmt_done (fmt_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream: signed decimal text of the value followed by CR LF.
  task automatic model(input logic [31:0] v, output byte_q_t q);
    longint s;
    longint m;
    q = {};
    s = longint'($signed(v));
    m = (s < 0) ? -s : s;
    if (m == 0) q.push_back(8'h30);
    while (m > 0) begin
      q.push_front(8'h30 + 8'(m % 10));
      m = m / 10;
    end
    if (s < 0) q.push_front(8'h2D);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic run(input logic [31:0] v, input bit rnd, input bit inject, input int rst_after);
    byte_q_t exp_q;
    byte_q_t got_q;
    int      cyc;
    int      first_v;
    int      n;
    bit      stalled;
    bit      finished;
    bit      injected;
    logic [7:0] held;

    model(v, exp_q);
    got_q    = {};
    first_v  = -1;
    stalled  = 1'b0;
    finished = 1'b0;
    injected = 1'b0;
    held     = 8'h00;

    @(negedge clk);
    alu_done = 1'b1;
    calc_res = v;
    tx_ready = 1'b0;
    @(negedge clk);
    alu_done = 1'b0;
    calc_res = $urandom;
    cyc = 1;

    while (cyc <= 600) begin
      if (alu_done) alu_done = 1'b0;
      if (stalled) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", {24'd0, tx_data}, {24'd0, held});
      end
      if (tx_valid && first_v < 0) first_v = cyc;
      check("busy", {31'd0, fmt_busy}, 32'd1);
      if (fmt_done) begin
        finished = 1'b1;
        break;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled  = tx_valid && !tx_ready;
      held     = tx_data;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (rst_after > 0 && got_q.size() == rst_after) begin
          @(negedge clk);
          n_rst = 1'b0;
          @(negedge clk);
          check("rst_tx_data", {24'd0, tx_data}, 32'd0);
          check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
          check("rst_busy", {31'd0, fmt_busy}, 32'd0);
          check("rst_done", {31'd0, fmt_done}, 32'd0);
          n_rst = 1'b1;
          for (int i = 0; i < rst_after; i++)
            check("rst_prefix", {24'd0, got_q[i]}, {24'd0, exp_q[i]});
          return;
        end
      end
      if (inject && !injected && got_q.size() == 2) begin
        alu_done = 1'b1;
        calc_res = 32'h00000001;
        injected = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end

    check("done_seen", {31'd0, finished}, 32'd1);
    check("first_valid_cycle", first_v, 32'd34);
    check("byte_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("byte%0d_of_%08h", i, v), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    @(negedge clk);
    check("done_pulse_once", {31'd0, fmt_done}, 32'd0);
    check("idle_busy", {31'd0, fmt_busy}, 32'd0);
    check("idle_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;

    n_rst    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_busy", {31'd0, fmt_busy}, 32'd0);
    check("reset_done", {31'd0, fmt_done}, 32'd0);
    n_rst = 1'b1;

    run(32'h00000000, 1'b0, 1'b0, 0);
    run(32'h0000007B, 1'b0, 1'b0, 0);
    run(32'hFFFFFF85, 1'b0, 1'b0, 0);
    run(32'h80000000, 1'b0, 1'b0, 0);
    run(32'h7FFFFFFF, 1'b0, 1'b0, 0);
    run(32'h00003039, 1'b1, 1'b1, 0);
    run(32'h00003039, 1'b0, 1'b0, 2);
    run(32'h00000009, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      if (i % 2 == 1) v = v >> $urandom_range(0, 31);
      run(v, 1'b1, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
